// File: rtl/mem_ctrl_pkg.sv
// Shared state, owner and length codes for the byte-serial RAM controller,
// plus byte selection and read-word assembly helpers.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        McIdle,
        McIRead,
        McMRead,
        McMWrite,
        McDone
    } mc_state_e;

    typedef enum logic {
        OwnIf,
        OwnMem
    } mc_owner_e;

    localparam logic [1:0] LenByte = 2'd0;
    localparam logic [1:0] LenHalf = 2'd1;
    localparam logic [1:0] LenWord = 2'd3;

    // Length code 2 has no three-byte access; it behaves as a full word.
    function automatic logic [1:0] norm_len(input logic [1:0] len);
        return (len == 2'd2) ? LenWord : len;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] assemble_word(input logic [1:0] len,
                                                  input logic [7:0] b0,
                                                  input logic [7:0] b1,
                                                  input logic [7:0] b2,
                                                  input logic [7:0] last_byte);
        case (len)
            LenByte: return {24'h0, last_byte};
            LenHalf: return {16'h0, last_byte, b0};
            default: return {last_byte, b2, b1, b0};
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller: arbitrates fetch and load/store word requests and
// sequences the per-byte accesses of the 8-bit single-port RAM.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i
);

    mc_state_e         state_q, state_d;
    mc_owner_e         owner_q, owner_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [7:0]        b2_q, b2_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;

    logic [1:0]        cnt_nxt;
    logic              last;

    assign cnt_nxt = cnt_q + 2'd1;
    assign last    = (cnt_q == len_q);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        rdata_d    = rdata_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = 1'b0;
        if_done_d  = 1'b0;
        mem_done_d = 1'b0;

        unique case (state_q)
            McIdle: begin
                cnt_d = 2'd0;
                // Load/store wins over fetch when both are pending.
                if (mem_req_i) begin
                    owner_d = OwnMem;
                    addr_d  = mem_addr_i;
                    len_d   = norm_len(mem_len_i);
                    wdata_d = mem_wdata_i;
                    ram_a_d = mem_addr_i;
                    if (mem_we_i) begin
                        state_d    = McMWrite;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata_i[7:0];
                    end else begin
                        state_d = McMRead;
                    end
                end else if (if_req_i) begin
                    state_d = McIRead;
                    owner_d = OwnIf;
                    addr_d  = if_addr_i;
                    len_d   = LenWord;
                    ram_a_d = if_addr_i;
                end
            end

            McIRead, McMRead: begin
                // A withdrawn fetch is a pipeline flush: drop it without a done pulse.
                if (state_q == McIRead && !if_req_i) begin
                    state_d = McIdle;
                end else if (last) begin
                    state_d    = McDone;
                    rdata_d    = assemble_word(len_q, b0_q, b1_q, b2_q, ram_din_i);
                    if_done_d  = (owner_q == OwnIf);
                    mem_done_d = (owner_q == OwnMem);
                end else begin
                    case (cnt_q)
                        2'd0:    b0_d = ram_din_i;
                        2'd1:    b1_d = ram_din_i;
                        default: b2_d = ram_din_i;
                    endcase
                    cnt_d   = cnt_nxt;
                    ram_a_d = addr_q + ADDR_W'(cnt_nxt);
                end
            end

            McMWrite: begin
                if (last) begin
                    state_d    = McDone;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_nxt;
                    ram_a_d    = addr_q + ADDR_W'(cnt_nxt);
                    ram_wr_d   = 1'b1;
                    ram_dout_d = byte_sel(wdata_q, cnt_nxt);
                end
            end

            McDone: begin
                state_d = McIdle;
            end

            default: begin
                state_d = McIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= McIdle;
            owner_q    <= OwnIf;
            cnt_q      <= 2'd0;
            len_q      <= LenByte;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            b0_q       <= 8'h0;
            b1_q       <= 8'h0;
            b2_q       <= 8'h0;
            rdata_q    <= 32'h0;
            ram_a_q    <= '0;
            ram_dout_q <= 8'h0;
            ram_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            rdata_q    <= rdata_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
        end
    end

    assign if_data_o   = rdata_q;
    assign mem_rdata_o = rdata_q;
    assign if_done_o   = if_done_q;
    assign mem_done_o  = mem_done_q;
    assign ram_a_o     = ram_a_q;
    assign ram_dout_o  = ram_dout_q;
    assign ram_wr_o    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed transactions push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_len = 2'd0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } mem_exp_t;

    logic [31:0] if_q[$];
    mem_exp_t    mem_q[$];

    // RAM model: asynchronous read, write on the rising edge.
    logic [7:0]  ram [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_idx = 12'h0;
    logic [7:0]  pre_dat = 8'h0;

    logic        log_en = 1'b0;
    logic [31:0] log_a[$];
    logic        log_wr[$];
    logic [7:0]  log_d[$];

    always #5 clk = ~clk;

    assign ram_din = ram[ram_a[11:0]];

    always @(posedge clk) begin
        if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
        else if (pre_we) ram[pre_idx] <= pre_dat;
    end

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_data_o  (if_data),
        .if_done_o  (if_done),
        .mem_req_i  (mem_req),
        .mem_we_i   (mem_we),
        .mem_len_i  (mem_len),
        .mem_addr_i (mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata),
        .mem_done_o (mem_done),
        .ram_a_o    (ram_a),
        .ram_dout_o (ram_dout),
        .ram_wr_o   (ram_wr),
        .ram_din_i  (ram_din)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare on every done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_done || mem_done) check("done_overlap", {63'h0, if_done & mem_done}, 64'h0);
            if (if_done) begin
                check("if_done_expected", {63'h0, if_q.size() != 0}, 64'h1);
                if (if_q.size() != 0) check("if_data", {32'h0, if_data}, {32'h0, if_q.pop_front()});
            end
            if (mem_done) begin
                check("mem_done_expected", {63'h0, mem_q.size() != 0}, 64'h1);
                if (mem_q.size() != 0) begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    if (e.chk) check("mem_rdata", {32'h0, mem_rdata}, {32'h0, e.data});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (log_en) begin
            log_a.push_back(ram_a);
            log_wr.push_back(ram_wr);
            log_d.push_back(ram_dout);
        end
    end

    task automatic log_clear();
        log_a.delete();
        log_wr.delete();
        log_d.delete();
    endtask

    // All tasks below start and end just after a rising edge.
    task automatic preload(input logic [11:0] idx, input logic [7:0] dat);
        pre_idx = idx;
        pre_dat = dat;
        pre_we  = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp, input int lat);
        int cycles = 0;
        bit got = 1'b0;
        if_q.push_back(exp);
        if_addr = addr;
        if_req  = 1'b1;
        while (!got && cycles < 30) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (if_done) got = 1'b1;
        end
        if_req = 1'b0;
        check("fetch_done_seen", {63'h0, got}, 64'h1);
        check("fetch_latency", 64'(cycles - 1), 64'(lat));
        @(posedge clk);
        #1;
    endtask

    task automatic do_mem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input int lat);
        int cycles = 0;
        bit got = 1'b0;
        mem_q.push_back('{chk: !we, data: exp});
        mem_we    = we;
        mem_len   = len;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_req   = 1'b1;
        while (!got && cycles < 30) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (mem_done) got = 1'b1;
        end
        mem_req = 1'b0;
        check("mem_done_seen", {63'h0, got}, 64'h1);
        check("mem_latency", 64'(cycles - 1), 64'(lat));
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ram_wr"}, {63'h0, ram_wr}, 64'h0);
        check({tag, "_ram_a"}, {32'h0, ram_a}, 64'h0);
        check({tag, "_ram_dout"}, {56'h0, ram_dout}, 64'h0);
        check({tag, "_dones"}, {62'h0, if_done, mem_done}, 64'h0);
        check({tag, "_data"}, {if_data, mem_rdata}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: word fetch
        preload(12'h100, 8'h13);
        preload(12'h101, 8'h00);
        preload(12'h102, 8'h00);
        preload(12'h103, 8'h93);
        log_clear();
        log_en = 1'b1;
        do_fetch(32'h100, 32'h9300_0013, 4);
        log_en = 1'b0;
        for (int k = 0; k < 4; k++) check("t1_ram_a", {32'h0, log_a[k+1]}, 64'(32'h100 + k));

        // 2: byte store then half load
        log_clear();
        log_en = 1'b1;
        do_mem(1'b1, 2'd0, 32'h2003, 32'hAABB_CCDD, 32'h0, 1);
        log_en = 1'b0;
        check("t2_wr_idle", {63'h0, log_wr[0]}, 64'h0);
        check("t2_wr", {63'h0, log_wr[1]}, 64'h1);
        check("t2_a", {32'h0, log_a[1]}, 64'h2003);
        check("t2_dout", {56'h0, log_d[1]}, 64'hDD);
        check("t2_wr_done", {63'h0, log_wr[2]}, 64'h0);
        preload(12'h002, 8'h11);
        do_mem(1'b0, 2'd1, 32'h2002, 32'h0, 32'h0000_DD11, 2);

        // 3: contention, mem first then fetch after DONE plus one idle cycle
        fork
            do_mem(1'b0, 2'd0, 32'h2003, 32'h0, 32'h0000_00DD, 1);
            do_fetch(32'h100, 32'h9300_0013, 7);
        join

        // 4: fetch abort after two bytes, then a clean fetch
        preload(12'h200, 8'h37);
        preload(12'h201, 8'h05);
        preload(12'h202, 8'h00);
        preload(12'h203, 8'h00);
        if_addr = 32'h100;
        if_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1 if_req = 1'b0;
        @(negedge clk);
        check("t4_no_done", {63'h0, if_done}, 64'h0);
        @(posedge clk);
        #1 check("t4_a_held", {32'h0, ram_a}, 64'h102);
        do_fetch(32'h200, 32'h0000_0537, 4);

        // 5: reset during byte 2 of a word store
        preload(12'h300, 8'h01);
        preload(12'h301, 8'h02);
        preload(12'h302, 8'h03);
        preload(12'h303, 8'h04);
        mem_we    = 1'b1;
        mem_len   = 2'd3;
        mem_addr  = 32'h300;
        mem_wdata = 32'hA4A3_A2A1;
        mem_req   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_wr_b2", {63'h0, ram_wr}, 64'h1);
        check("t5_a_b2", {32'h0, ram_a}, 64'h302);
        check("t5_dout_b2", {56'h0, ram_dout}, 64'hA3);
        #1 rst = 1'b1;
        #1 check_outputs_zero("t5_async");
        mem_req = 1'b0;
        mem_we  = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("t5_wr_held", {63'h0, ram_wr}, 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_mem(1'b0, 2'd3, 32'h300, 32'h0, 32'h0403_A2A1, 4);

        // 6: address wrap
        preload(12'hFFE, 8'h11);
        preload(12'hFFF, 8'h22);
        preload(12'h000, 8'h33);
        preload(12'h001, 8'h44);
        log_clear();
        log_en = 1'b1;
        do_mem(1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0, 32'h4433_2211, 4);
        log_en = 1'b0;
        check("t6_a0", {32'h0, log_a[1]}, 64'hFFFF_FFFE);
        check("t6_a1", {32'h0, log_a[2]}, 64'hFFFF_FFFF);
        check("t6_a2", {32'h0, log_a[3]}, 64'h0);
        check("t6_a3", {32'h0, log_a[4]}, 64'h1);

        repeat (3) @(posedge clk);
        check("if_queue_drained", 64'(if_q.size()), 64'h0);
        check("mem_queue_drained", 64'(mem_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
